// File: rtl/vec_mem_unit_if.sv
// Decoder, vector/mask-register and memory-network signals of the vector memory unit.
// master = decoder/regfile/network side, slave = vec_mem_unit.
interface vec_mem_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int IDX_W  = 6
);
   logic              start;
   logic              rw;
   logic [1:0]        mode;
   logic              mask_en;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] stride;
   logic [IDX_W:0]    vl;
   logic [IDX_W-1:0]  elem_index;
   logic              mask_bit;
   logic [DATA_W-1:0] vec_rdata;
   logic [DATA_W-1:0] idx_data;
   logic [DATA_W-1:0] vec_wdata;
   logic              vec_we;
   logic              mem_req;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_halt;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, rw, mode, mask_en, base, stride, vl,
      output mask_bit, vec_rdata, idx_data, mem_ack, mem_rdata, mem_halt,
      input  elem_index, vec_wdata, vec_we, mem_req, mem_rw, mem_addr, mem_wdata,
      input  busy, done, err
   );

   modport slave (
      input  start, rw, mode, mask_en, base, stride, vl,
      input  mask_bit, vec_rdata, idx_data, mem_ack, mem_rdata, mem_halt,
      output elem_index, vec_wdata, vec_we, mem_req, mem_rw, mem_addr, mem_wdata,
      output busy, done, err
   );
endinterface

// File: rtl/vec_mem_unit.sv
// Vector load/store walker (unit, strided, indexed, masked): one network request per active element.
// Per element: store 2, load 3, masked-off 1 cycle; mem_halt stalls ISSUE, REQ waits for mem_ack.
module vec_mem_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int VLEN   = 64,
   parameter int IDX_W  = $clog2(VLEN)
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   vec_mem_unit_if.slave  io_bus
);
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_REQ, S_WB, S_FIN} state_t;

   localparam logic [1:0]     M_STRD = 2'b01;
   localparam logic [1:0]     M_IDX  = 2'b10;
   localparam logic [1:0]     M_ILL  = 2'b11;
   localparam logic [IDX_W:0] VL_MAX = (IDX_W+1)'(VLEN);

   state_t            r_state,     w_state;
   logic              r_rw,        w_rw;
   logic [1:0]        r_mode,      w_mode;
   logic              r_mask_en,   w_mask_en;
   logic [ADDR_W-1:0] r_base,      w_base;
   logic [ADDR_W-1:0] r_stride,    w_stride;
   logic [IDX_W:0]    r_vl,        w_vl;
   logic [ADDR_W-1:0] r_off,       w_off;
   logic [IDX_W-1:0]  r_idx,       w_idx;
   logic [DATA_W-1:0] r_vec_wdata, w_vec_wdata;
   logic              r_vec_we,    w_vec_we;
   logic              r_mem_req,   w_mem_req;
   logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
   logic              r_busy,      w_busy;
   logic              r_done,      w_done;
   logic              r_err,       w_err;

   logic              w_adv;
   logic              w_last;
   logic [IDX_W:0]    w_vl_in;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W-1:0] w_step;

   assign w_vl_in = (io_bus.vl > VL_MAX) ? VL_MAX : io_bus.vl;
   assign w_last  = ({1'b0, r_idx} == (r_vl - (IDX_W+1)'(1)));
   // Stride is ADDR_W wide, so modular addition already sign-extends it.
   assign w_step  = (r_mode == M_STRD) ? r_stride : ADDR_W'(1);
   assign w_addr  = (r_mode == M_IDX) ? (r_base + io_bus.idx_data[ADDR_W-1:0])
                                      : (r_base + r_off);

   always_comb begin
      w_state     = r_state;
      w_rw        = r_rw;
      w_mode      = r_mode;
      w_mask_en   = r_mask_en;
      w_base      = r_base;
      w_stride    = r_stride;
      w_vl        = r_vl;
      w_off       = r_off;
      w_idx       = r_idx;
      w_vec_wdata = r_vec_wdata;
      w_vec_we    = 1'b0;
      w_mem_req   = r_mem_req;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_adv       = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (io_bus.start) begin
               w_rw      = io_bus.rw;
               w_mode    = io_bus.mode;
               w_mask_en = io_bus.mask_en;
               w_base    = io_bus.base;
               w_stride  = io_bus.stride;
               w_vl      = w_vl_in;
               w_off     = '0;
               w_idx     = '0;
               if ((w_vl_in == '0) || (io_bus.mode == M_ILL)) begin
                  w_state = S_FIN;
                  w_done  = 1'b1;
                  w_err   = (io_bus.mode == M_ILL);
               end else begin
                  w_state = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (r_mask_en && !io_bus.mask_bit) begin
               w_off = r_off + w_step;
               w_adv = 1'b1;
            end else if (!io_bus.mem_halt) begin
               w_state     = S_REQ;
               w_mem_req   = 1'b1;
               w_mem_addr  = w_addr;
               w_mem_wdata = io_bus.vec_rdata;
               w_off       = r_off + w_step;
            end
         end
         S_REQ: begin
            if (io_bus.mem_ack) begin
               w_mem_req = 1'b0;
               if (r_rw) begin
                  w_adv = 1'b1;
               end else begin
                  w_vec_wdata = io_bus.mem_rdata;
                  w_vec_we    = 1'b1;
                  w_state     = S_WB;
               end
            end
         end
         S_WB:    w_adv   = 1'b1;
         S_FIN:   w_state = S_IDLE;
         default: w_state = S_IDLE;
      endcase

      if (w_adv) begin
         if (w_last) begin
            w_state = S_FIN;
            w_done  = 1'b1;
         end else begin
            w_idx   = r_idx + IDX_W'(1);
            w_state = S_ISSUE;
         end
      end

      w_busy = (w_state != S_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_rw        <= 1'b0;
         r_mode      <= '0;
         r_mask_en   <= 1'b0;
         r_base      <= '0;
         r_stride    <= '0;
         r_vl        <= '0;
         r_off       <= '0;
         r_idx       <= '0;
         r_vec_wdata <= '0;
         r_vec_we    <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_rw        <= w_rw;
         r_mode      <= w_mode;
         r_mask_en   <= w_mask_en;
         r_base      <= w_base;
         r_stride    <= w_stride;
         r_vl        <= w_vl;
         r_off       <= w_off;
         r_idx       <= w_idx;
         r_vec_wdata <= w_vec_wdata;
         r_vec_we    <= w_vec_we;
         r_mem_req   <= w_mem_req;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_busy      <= w_busy;
         r_done      <= w_done;
         r_err       <= w_err;
      end
   end

   assign io_bus.elem_index = r_idx;
   assign io_bus.vec_wdata  = r_vec_wdata;
   assign io_bus.vec_we     = r_vec_we;
   assign io_bus.mem_req    = r_mem_req;
   assign io_bus.mem_rw     = r_rw;
   assign io_bus.mem_addr   = r_mem_addr;
   assign io_bus.mem_wdata  = r_mem_wdata;
   assign io_bus.busy       = r_busy;
   assign io_bus.done       = r_done;
   assign io_bus.err        = r_err;
endmodule

// File: tb/tb_vec_mem_unit.sv
// Directed bench for vec_mem_unit: memory-network responder plus request/writeback scoreboards.
module tb_vec_mem_unit;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   localparam int VLEN   = 64;
   localparam int IDX_W  = 6;

   typedef struct packed {
      logic        rw;
      logic [8:0]  addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic [5:0]  idx;
      logic [31:0] data;
   } wb_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vec_mem_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

   vec_mem_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .VLEN(VLEN), .IDX_W(IDX_W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   logic [31:0] vreg    [VLEN];
   logic        mask_v  [VLEN];
   logic [31:0] idxv    [VLEN];
   logic [31:0] mem     [512];
   logic        wr_flag [512];
   int ack_delay = 0;
   int req_cnt   = 0;
   int cyc_cnt   = 0;

   function automatic logic [31:0] mem_val(input logic [8:0] a);
      return wr_flag[a] ? mem[a] : (32'hC0DE_0000 | {23'd0, a});
   endfunction

   assign bus.vec_rdata = vreg[bus.elem_index];
   assign bus.mask_bit  = mask_v[bus.elem_index];
   assign bus.idx_data  = idxv[bus.elem_index];
   assign bus.mem_ack   = bus.mem_req && (req_cnt >= ack_delay);
   assign bus.mem_rdata = mem_val(bus.mem_addr);

   // Network model: ack after ack_delay waiting cycles, stores land on the acking edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_cnt <= 0;
         for (int i = 0; i < 512; i++) wr_flag[i] <= 1'b0;
      end else begin
         req_cnt <= (bus.mem_req && !bus.mem_ack) ? req_cnt + 1 : 0;
         if (bus.mem_req && bus.mem_ack && bus.mem_rw) begin
            mem[bus.mem_addr]     <= bus.mem_wdata;
            wr_flag[bus.mem_addr] <= 1'b1;
         end
      end
   end

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   req_t exp_req[$];
   wb_t  exp_wb[$];
   int   n_cmp = 0;
   int   n_mis = 0;
   int   n_acc = 0;
   int   n_we  = 0;
   int   exp_nreq, exp_nwe, t0, acc0, we0, lat;
   req_t prev_req;
   logic prev_pend = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task observe;
      req_t cur, e_r;
      wb_t  wcur, e_w;
      cur = {bus.mem_rw, bus.mem_addr, bus.mem_wdata};
      if (bus.mem_req && prev_pend) chk("req_hold", cur, prev_req);
      if (bus.mem_req && bus.mem_ack) begin
         n_acc++;
         chk("req_expected", exp_req.size() != 0, 1'b1);
         if (exp_req.size() != 0) begin
            e_r = exp_req.pop_front();
            chk("req", cur, e_r);
         end
      end
      if (bus.vec_we) begin
         n_we++;
         wcur = {bus.elem_index, bus.vec_wdata};
         chk("wb_expected", exp_wb.size() != 0, 1'b1);
         if (exp_wb.size() != 0) begin
            e_w = exp_wb.pop_front();
            chk("wb", wcur, e_w);
         end
      end
      prev_pend = bus.mem_req && !bus.mem_ack;
      prev_req  = cur;
   endtask

   task tick;
      @(negedge clk);
      observe();
   endtask

   // Expected requests come from closed-form offsets (i*stride), not a running sum.
   task launch(input logic rw, input logic [1:0] mode, input logic men, input logic [8:0] base,
               input logic [8:0] stride, input logic [6:0] vl);
      int n;
      logic [8:0] a, off;
      n = (vl > 7'd64) ? 64 : int'(vl);
      if (mode == 2'b11) n = 0;
      exp_nreq = 0;
      exp_nwe  = 0;
      for (int i = 0; i < n; i++) begin
         if (!(men && !mask_v[i])) begin
            off = (mode == 2'b01) ? 9'(i) * stride : 9'(i);
            a   = (mode == 2'b10) ? base + idxv[i][8:0] : base + off;
            exp_req.push_back({rw, a, vreg[i]});
            exp_nreq++;
            if (!rw) begin
               exp_wb.push_back({6'(i), mem_val(a)});
               exp_nwe++;
            end
         end
      end
      bus.rw = rw; bus.mode = mode; bus.mask_en = men;
      bus.base = base; bus.stride = stride; bus.vl = vl;
      bus.start = 1'b1;
      t0   = cyc_cnt;
      acc0 = n_acc;
      we0  = n_we;
      tick();
      bus.start = 1'b0;
      chk("busy_after_start", bus.busy, 1'b1);
   endtask

   task finish(input string tag, input int exp_lat, input logic exp_err);
      lat = -1;
      for (int k = 0; k < 400; k++) begin
         if (bus.done) begin
            lat = cyc_cnt - t0;
            break;
         end
         tick();
      end
      chk({tag, "_done_seen"}, lat >= 0, 1'b1);
      if (lat >= 0) begin
         if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
         chk({tag, "_err"}, bus.err, exp_err);
      end
      chk({tag, "_nreq"}, n_acc - acc0, exp_nreq);
      chk({tag, "_nwe"}, n_we - we0, exp_nwe);
      chk({tag, "_req_q_left"}, exp_req.size(), 0);
      chk({tag, "_wb_q_left"}, exp_wb.size(), 0);
      tick();
      chk({tag, "_idle"}, {bus.busy, bus.done}, 2'b00);
   endtask

   initial begin
      bus.start = 1'b0; bus.rw = 1'b0; bus.mode = 2'b00; bus.mask_en = 1'b0;
      bus.base = '0; bus.stride = '0; bus.vl = '0; bus.mem_halt = 1'b0;
      for (int i = 0; i < VLEN; i++) begin
         vreg[i]   = $urandom;
         mask_v[i] = 1'b0;
         idxv[i]   = '0;
      end

      repeat (3) @(negedge clk);
      chk("rst_flags", {bus.busy, bus.done, bus.err, bus.mem_req, bus.vec_we, bus.mem_rw}, 6'd0);
      chk("rst_index", bus.elem_index, 6'd0);
      chk("rst_addr", bus.mem_addr, 9'd0);
      rst_n = 1'b1;
      tick();

      // unit-stride load, immediate ack: 4 x (ISSUE,REQ,WB) then FIN
      launch(1'b0, 2'b00, 1'b0, 9'h010, 9'h000, 7'd4);
      finish("unit_ld", 13, 1'b0);

      launch(1'b1, 2'b01, 1'b0, 9'h004, 9'h1FE, 7'd4);
      finish("strd_st", 9, 1'b0);
      chk("strd_st_mem1fe", mem_val(9'h1FE), vreg[3]);
      chk("strd_st_mem000", mem_val(9'h000), vreg[2]);

      mask_v[1] = 1'b1;
      mask_v[3] = 1'b1;
      launch(1'b0, 2'b00, 1'b1, 9'h040, 9'h000, 7'd4);
      finish("mask_ld", 9, 1'b0);

      // 5 halted ISSUE cycles, then two stores each waiting 4 REQ cycles: 5+1+4+1+4+FIN = 16
      bus.mem_halt = 1'b1;
      ack_delay    = 3;
      launch(1'b1, 2'b00, 1'b0, 9'h020, 9'h000, 7'd2);
      for (int k = 0; k < 5; k++) begin
         chk("halt_no_req", bus.mem_req, 1'b0);
         if (k == 1) begin
            bus.start = 1'b1; bus.rw = 1'b0; bus.base = 9'h1AA; bus.vl = 7'd8;
         end else begin
            bus.start = 1'b0;
         end
         tick();
      end
      bus.mem_halt = 1'b0;
      finish("halt_st", 16, 1'b0);
      ack_delay = 0;

      launch(1'b0, 2'b00, 1'b0, 9'h050, 9'h000, 7'd0);
      finish("vl0", 0, 1'b0);
      chk("vl0_latency_le2", (lat >= 1) && (lat <= 2), 1'b1);

      launch(1'b1, 2'b11, 1'b0, 9'h060, 9'h000, 7'd4);
      finish("illegal", 0, 1'b1);

      ack_delay = 3;
      launch(1'b1, 2'b00, 1'b0, 9'h030, 9'h000, 7'd4);
      for (int k = 0; k < 10; k++) if (!bus.mem_req) tick();
      chk("rst_req_seen", bus.mem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_flags", {bus.busy, bus.done, bus.err, bus.mem_req, bus.vec_we, bus.mem_rw}, 6'd0);
      chk("midrst_addr", bus.mem_addr, 9'd0);
      chk("midrst_wdata", bus.mem_wdata, 32'd0);
      chk("midrst_vwdata", bus.vec_wdata, 32'd0);
      exp_req.delete();
      exp_wb.delete();
      prev_pend = 1'b0;
      tick();
      tick();
      rst_n     = 1'b1;
      ack_delay = 0;
      tick();

      idxv[0] = 32'd7; idxv[1] = 32'd3; idxv[2] = 32'h1FF; idxv[3] = 32'd1;
      launch(1'b0, 2'b10, 1'b0, 9'h100, 9'h000, 7'd4);
      finish("idx_ld", 13, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
